// File: rtl/fp_result_queue.sv
// Result FIFO behind the floating-point ALU: stores result, flags, op and IEEE-754 class per entry.
// Optional sticky flag accumulation is enabled by defining FP_STICKY_FLAGS_EN.
module fp_result_queue #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_result,
    input  logic          in_carry,
    input  logic          in_overflow,
    input  logic          in_op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_result,
    output logic          out_carry,
    output logic          out_overflow,
    output logic          out_op,
    output logic [3:0]    out_class,
    output logic [CW-1:0] count,
    input  logic          clr_sticky,
    output logic [3:0]    sticky
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] result;
        logic        carry;
        logic        overflow;
        logic        op;
        logic [3:0]  cls;
    } entry_t;

    // Class bits are {nan, inf, denorm, zero}; a normal number leaves all four clear.
    function automatic logic [3:0] classify(input logic [31:0] value);
        logic [7:0]  exp_field;
        logic [22:0] man_field;
        logic        exp_zero;
        logic        exp_ones;
        logic        man_zero;
        exp_field = value[30:23];
        man_field = value[22:0];
        exp_zero  = (exp_field == 8'h00);
        exp_ones  = (exp_field == 8'hFF);
        man_zero  = (man_field == 23'd0);
        return {exp_ones & ~man_zero, exp_ones & man_zero,
                exp_zero & ~man_zero, exp_zero & man_zero};
    endfunction

    entry_t          mem_reg [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   wr_ptr_next;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   rd_ptr_next;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    entry_t          in_entry;
    entry_t          head;
    logic [DEPTH-1:0] wr_sel;
    logic [DEPTH-1:0] rd_sel;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign push     = in_valid && !full;
    assign pop      = !empty && out_ready;

    assign in_entry.result   = in_result;
    assign in_entry.carry    = in_carry;
    assign in_entry.overflow = in_overflow;
    assign in_entry.op       = in_op;
    assign in_entry.cls      = classify(in_result);

    // Per-slot write and release strobes decoded from the pointers.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_sel
            assign wr_sel[gi] = push && (wr_ptr_reg == AW'(gi));
            assign rd_sel[gi] = pop  && (rd_ptr_reg == AW'(gi));
        end
    endgenerate

    // A popped slot is zeroed so an empty queue always presents zero data at the head.
    // Write and release never target the same slot: that needs empty (no pop) or full (no push).
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                mem_reg[i] <= '0;
            end else if (wr_sel[i]) begin
                mem_reg[i] <= in_entry;
            end else if (rd_sel[i]) begin
                mem_reg[i] <= '0;
            end
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign head         = mem_reg[rd_ptr_reg];
    assign out_valid    = !empty;
    assign in_ready     = !full;
    assign out_result   = head.result;
    assign out_carry    = head.carry;
    assign out_overflow = head.overflow;
    assign out_op       = head.op;
    assign out_class    = head.cls;
    assign count        = count_reg;

`ifdef FP_STICKY_FLAGS_EN
    logic [3:0] sticky_reg;
    logic [3:0] sticky_next;

    // A push in the same cycle as a clear still contributes its own flags.
    always_comb begin
        sticky_next = sticky_reg;
        if (push) begin
            sticky_next = (clr_sticky ? 4'b0000 : sticky_reg)
                        | {in_overflow, in_carry, in_entry.cls[3], in_entry.cls[2]};
        end else if (clr_sticky) begin
            sticky_next = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_reg <= 4'b0000;
        end else begin
            sticky_reg <= sticky_next;
        end
    end

    assign sticky = sticky_reg;
`else
    logic unused_clr_sticky;
    assign unused_clr_sticky = clr_sticky;
    assign sticky            = 4'b0000;
`endif

endmodule

// File: tb/tb_fp_result_queue.sv
// Scoreboard bench for fp_result_queue: directed scenarios followed by randomized traffic.
module tb_fp_result_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_result;
    logic          in_carry;
    logic          in_overflow;
    logic          in_op;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_result;
    logic          out_carry;
    logic          out_overflow;
    logic          out_op;
    logic [3:0]    out_class;
    logic [CW-1:0] count;
    logic          clr_sticky;
    logic [3:0]    sticky;

    always #5 clk = ~clk;

    fp_result_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_carry     (in_carry),
        .in_overflow  (in_overflow),
        .in_op        (in_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .out_op       (out_op),
        .out_class    (out_class),
        .count        (count),
        .clr_sticky   (clr_sticky),
        .sticky       (sticky)
    );

    typedef struct packed {
        logic [31:0] result;
        logic        carry;
        logic        overflow;
        logic        op;
        logic [3:0]  cls;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    bit         model_valid = 1'b0;
    logic [3:0] sticky_exp = 4'b0000;

    // Class from the IEEE-754 field rules, using plain integer arithmetic.
    function automatic logic [3:0] ref_class(input logic [31:0] r);
        int unsigned e;
        int unsigned m;
        e = (r / 32'h0080_0000) % 256;
        m = r % 32'h0080_0000;
        if (e == 0 && m == 0)   return 4'b0001;
        if (e == 0)             return 4'b0010;
        if (e == 255 && m == 0) return 4'b0100;
        if (e == 255)           return 4'b1000;
        return 4'b0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares DUT state against the scoreboard, then applies this cycle's handshakes.
    always @(negedge clk) begin
        bit   do_push;
        bit   do_pop;
        exp_t e;
        if (model_valid) begin
            chk("count", 32'(count), 32'(sb.size()));
            chk("in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
            chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            chk("sticky", 32'(sticky), 32'(sticky_exp));
            if (sb.size() == 0) begin
                chk("empty_out_result", out_result, 32'h0);
            end else begin
                e = sb[0];
                chk("head_result", out_result, e.result);
                chk("head_carry", 32'(out_carry), 32'(e.carry));
                chk("head_overflow", 32'(out_overflow), 32'(e.overflow));
                chk("head_op", 32'(out_op), 32'(e.op));
                chk("head_class", 32'(out_class), 32'(e.cls));
            end
        end
        if (rst) begin
            sb.delete();
            sticky_exp  = 4'b0000;
            model_valid = 1'b1;
        end else if (model_valid) begin
            do_pop  = out_ready && (sb.size() > 0);
            do_push = in_valid && (sb.size() < DEPTH);
            if (do_pop) begin
                e = sb.pop_front();
                $display("pop  result=%h carry=%b ovf=%b op=%b class=%b", e.result, e.carry, e.overflow, e.op, e.cls);
            end
            if (do_push) begin
                e.result   = in_result;
                e.carry    = in_carry;
                e.overflow = in_overflow;
                e.op       = in_op;
                e.cls      = ref_class(in_result);
                sb.push_back(e);
            end
`ifdef FP_STICKY_FLAGS_EN
            if (do_push) begin
                sticky_exp = (clr_sticky ? 4'b0000 : sticky_exp)
                           | {in_overflow, in_carry, ref_class(in_result) == 4'b1000, ref_class(in_result) == 4'b0100};
            end else if (clr_sticky) begin
                sticky_exp = 4'b0000;
            end
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] specials [8];
    logic [31:0] class_vals [5];
    logic [3:0]  class_req [5];

    initial begin
        specials   = '{32'h0000_0000, 32'h0000_0001, 32'h7F80_0000, 32'h7FC0_0000,
                       32'hFF80_0000, 32'h8000_0000, 32'h807F_FFFF, 32'h3F80_0000};
        class_vals = '{32'h0000_0000, 32'h0000_0001, 32'h7F80_0000, 32'h7FC0_0000, 32'hFF80_0000};
        class_req  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};

        rst = 1'b1; in_valid = 1'b1; in_result = 32'h1234_5678;
        in_carry = 1'b1; in_overflow = 1'b1; in_op = 1'b1;
        out_ready = 1'b0; clr_sticky = 1'b0;
        step(); step();
        rst = 1'b0; in_valid = 1'b0; in_carry = 1'b0; in_overflow = 1'b0; in_op = 1'b0;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_result", out_result, 32'h0);
        chk("reset_sticky", 32'(sticky), 32'd0);

        // Ordering and one-cycle latency
        in_valid = 1'b1; in_result = 32'h3F80_0000; in_op = 1'b0;
        step();
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        in_result = 32'h4000_0000; in_op = 1'b1;
        step();
        in_valid = 1'b0;
        chk("order_count", 32'(count), 32'd2);
        chk("order_head", out_result, 32'h3F80_0000);
        out_ready = 1'b1;
        step();
        chk("order_second", out_result, 32'h4000_0000);
        step();
        out_ready = 1'b0;

        // Full and back-pressure
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_result = 32'h4100_0000 + 32'(i);
            step();
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_result = 32'h4100_0004;
        step();
        chk("full_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("after_pop_in_ready", 32'(in_ready), 32'd1);
        chk("after_pop_count", 32'(count), 32'd3);
        step();
        in_valid = 1'b0;
        chk("refill_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b0;

        // Simultaneous push and pop across pointer wrap
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_result = 32'h4200_0000 + 32'(i);
            step();
        end
        out_ready = 1'b1;
        for (int i = 2; i < 8; i++) begin
            in_result = 32'h4200_0000 + 32'(i);
            step();
            chk("simul_count", 32'(count), 32'd2);
        end
        in_valid = 1'b0;
        step(); step();
        out_ready = 1'b0;

        // Classification
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_result = class_vals[i];
            step();
            in_valid = 1'b0;
            chk("class", 32'(out_class), 32'(class_req[i]));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end

        // Sticky flags
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        in_valid = 1'b1; in_result = 32'h7FC0_0000; in_overflow = 1'b1; in_carry = 1'b0;
        step();
        in_valid = 1'b0; in_overflow = 1'b0;
`ifdef FP_STICKY_FLAGS_EN
        chk("sticky_nan_ovf", 32'(sticky), 32'(4'b1010));
`else
        chk("sticky_tied", 32'(sticky), 32'd0);
`endif
        clr_sticky = 1'b1; in_valid = 1'b1; in_result = 32'h7F80_0000; in_carry = 1'b1;
        step();
        clr_sticky = 1'b0; in_valid = 1'b0; in_carry = 1'b0;
`ifdef FP_STICKY_FLAGS_EN
        chk("sticky_clr_push", 32'(sticky), 32'(4'b0101));
`else
        chk("sticky_tied2", 32'(sticky), 32'd0);
`endif
        out_ready = 1'b1;
        step(); step();
        out_ready = 1'b0;

        // Randomized traffic with occasional reset and sticky clear
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            in_result   = ($urandom_range(0, 1) == 0) ? specials[$urandom_range(0, 7)] : $urandom;
            in_carry    = 1'($urandom_range(0, 1));
            in_overflow = ($urandom_range(0, 7) == 0);
            in_op       = 1'($urandom_range(0, 1));
            clr_sticky  = ($urandom_range(0, 15) == 0);
            step();
        end

        rst = 1'b0; in_valid = 1'b0; clr_sticky = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("drained_count", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
